// File: rtl/stopwatch_counter.sv
// Stopwatch time base and mm:ss.cc BCD accumulator.
// Driven by the 2-bit mode code from the stopwatch control FSM.
module stopwatch_counter #(
  parameter int TICK_DIV = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  en,
  output logic [23:0] bcd,
  output logic        tick,
  output logic        wrap,
  output logic        running
);

  localparam int PW = $clog2(TICK_DIV);
  // Per-digit maxima, packed like bcd: mm:ss.cc
  localparam logic [23:0] LIM = 24'h595999;

  logic [PW-1:0] psc;
  logic [23:0]   digits;
  logic [23:0]   nxt;
  logic          carry;
  logic          tick_now;
  logic          cnt_mode;
  logic          hold_mode;

  assign bcd       = digits;
  assign tick_now  = (psc == PW'(TICK_DIV - 1));
  assign cnt_mode  = (en == 2'b01);
  assign hold_mode = (en == 2'b10);

  // Whole carry chain settles in one cycle
  always_comb begin
    nxt   = digits;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (digits[4*i +: 4] == LIM[4*i +: 4]) begin
          nxt[4*i +: 4] = 4'd0;
        end else begin
          nxt[4*i +: 4] = digits[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc     <= '0;
      digits  <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      running <= 1'b0;
    end else begin
      running <= cnt_mode;
      unique case (1'b1)
        cnt_mode: begin
          if (tick_now) begin
            psc    <= '0;
            digits <= nxt;
            tick   <= 1'b1;
            wrap   <= carry;
          end else begin
            psc  <= psc + 1'b1;
            tick <= 1'b0;
            wrap <= 1'b0;
          end
        end
        hold_mode: begin
          tick <= 1'b0;
          wrap <= 1'b0;
        end
        default: begin
          psc    <= '0;
          digits <= '0;
          tick   <= 1'b0;
          wrap   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with a scoreboard queue.
// Instance a uses TICK_DIV=4, instance b uses TICK_DIV=2.
module tb_stopwatch_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  en_a, en_b;
  logic [23:0] bcd_a, bcd_b;
  logic        tick_a, tick_b;
  logic        wrap_a, wrap_b;
  logic        running_a, running_b;

  int checks;
  int failures;
  int ticks_a;

  int psc [2];
  int cs  [2];
  bit run [2];

  logic [26:0] sb [$];

  stopwatch_counter #(.TICK_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .bcd(bcd_a),
    .tick(tick_a), .wrap(wrap_a), .running(running_a)
  );

  stopwatch_counter #(.TICK_DIV(2)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .bcd(bcd_b),
    .tick(tick_b), .wrap(wrap_b), .running(running_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(int c);
    int m, s, h;
    m = c / 6000;
    s = (c / 100) % 60;
    h = c % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10),
            4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  // Reference behaviour in centiseconds, not digits
  function automatic logic [26:0] model(int i, logic [1:0] e, int d);
    bit t, w;
    t = 0;
    w = 0;
    run[i] = (e == 2'b01);
    if (e == 2'b01) begin
      if (psc[i] == d - 1) begin
        psc[i] = 0;
        t = 1;
        if (cs[i] == 359999) begin
          cs[i] = 0;
          w = 1;
        end else begin
          cs[i] = cs[i] + 1;
        end
      end else begin
        psc[i] = psc[i] + 1;
      end
    end else if (e != 2'b10) begin
      psc[i] = 0;
      cs[i]  = 0;
    end
    return {to_bcd(cs[i]), t, w, run[i]};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] ea, input logic [1:0] eb);
    en_a = ea;
    en_b = eb;
    sb.push_back(model(0, ea, 4));
    sb.push_back(model(1, eb, 2));
    @(posedge clk);
    #1;
    if (tick_a) ticks_a++;
    chk("edge_a", {5'd0, bcd_a, tick_a, wrap_a, running_a},
        {5'd0, sb.pop_front()});
    chk("edge_b", {5'd0, bcd_b, tick_b, wrap_b, running_b},
        {5'd0, sb.pop_front()});
  endtask

  task automatic run_n(int n, logic [1:0] ea, logic [1:0] eb);
    for (int k = 0; k < n; k++) step(ea, eb);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ticks_a  = 0;
    for (int i = 0; i < 2; i++) begin
      psc[i] = 0;
      cs[i]  = 0;
      run[i] = 0;
    end
    en_a  = 2'b00;
    en_b  = 2'b00;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", {5'd0, bcd_a, tick_a, wrap_a, running_a}, 32'd0);
    chk("rst_b", {5'd0, bcd_b, tick_b, wrap_b, running_b}, 32'd0);
    reset = 1'b1;

    // Basic count on a: 40 enabled edges -> 10 ticks
    step(2'b00, 2'b10);
    ticks_a = 0;
    run_n(3, 2'b01, 2'b10);
    chk("no_tick_e3", {31'd0, tick_a}, 32'd0);
    step(2'b01, 2'b10);
    chk("first_tick_e4", {31'd0, tick_a}, 32'd1);
    run_n(36, 2'b01, 2'b10);
    chk("ticks_40", ticks_a, 32'd10);
    chk("bcd_40", {8'd0, bcd_a}, 32'h000010);

    // Hold keeps the partial prescaler
    step(2'b00, 2'b10);
    run_n(6, 2'b01, 2'b10);
    chk("hold_pre", {8'd0, bcd_a}, 32'h000001);
    ticks_a = 0;
    run_n(20, 2'b10, 2'b10);
    chk("hold_bcd", {8'd0, bcd_a}, 32'h000001);
    chk("hold_ticks", ticks_a, 32'd0);
    step(2'b01, 2'b10);
    chk("resume_e1", {31'd0, tick_a}, 32'd0);
    step(2'b01, 2'b10);
    chk("resume_e2", {31'd0, tick_a}, 32'd1);
    chk("resume_bcd", {8'd0, bcd_a}, 32'h000002);

    // Carries on b
    step(2'b10, 2'b00);
    run_n(200, 2'b10, 2'b01);
    chk("cnt_100", {8'd0, bcd_b}, 32'h000100);
    run_n(1798, 2'b10, 2'b01);
    chk("pre_1000", {8'd0, bcd_b}, 32'h000999);
    step(2'b10, 2'b01);
    step(2'b10, 2'b01);
    chk("to_1000", {8'd0, bcd_b}, 32'h001000);
    run_n(9998, 2'b10, 2'b01);
    chk("pre_min", {8'd0, bcd_b}, 32'h005999);
    step(2'b10, 2'b01);
    step(2'b10, 2'b01);
    chk("to_min", {8'd0, bcd_b}, 32'h010000);

    // Clear and illegal codes on what would be a tick edge
    for (int k = 0; k < 2; k++) begin
      step(2'b10, 2'b00);
      run_n(1046, 2'b10, 2'b01);
      chk("at_523", {8'd0, bcd_b}, 32'h000523);
      step(2'b10, 2'b01);
      step(2'b10, (k == 0) ? 2'b00 : 2'b11);
      chk("clr_bcd", {8'd0, bcd_b}, 32'd0);
      chk("clr_tick", {31'd0, tick_b}, 32'd0);
      chk("clr_run", {31'd0, running_b}, 32'd0);
      step(2'b10, 2'b01);
      chk("clr_pre0", {31'd0, tick_b}, 32'd0);
      step(2'b10, 2'b01);
      chk("clr_pre1", {8'd0, bcd_b}, 32'h000001);
    end

    // Wrap: preload 59:59.99 while holding
    step(2'b10, 2'b00);
    step(2'b10, 2'b01);
    @(negedge clk);
    force dut_b.digits = 24'h595999;
    cs[1] = 359999;
    step(2'b10, 2'b10);
    @(negedge clk);
    release dut_b.digits;
    step(2'b10, 2'b10);
    chk("pre_wrap", {8'd0, bcd_b}, 32'h595999);
    step(2'b10, 2'b01);
    chk("wrap_pulse", {5'd0, bcd_b, tick_b, wrap_b, running_b},
        {5'd0, 24'h000000, 3'b111});
    step(2'b10, 2'b01);
    chk("wrap_low", {31'd0, wrap_b}, 32'd0);
    step(2'b10, 2'b01);
    chk("post_wrap", {5'd0, bcd_b, tick_b, wrap_b, running_b},
        {5'd0, 24'h000001, 3'b101});

    // Asynchronous reset mid-run
    step(2'b10, 2'b00);
    run_n(274, 2'b10, 2'b01);
    chk("at_137", {8'd0, bcd_b}, 32'h000137);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst", {5'd0, bcd_b, tick_b, wrap_b, running_b}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      psc[i] = 0;
      cs[i]  = 0;
      run[i] = 0;
    end
    @(negedge clk);
    reset = 1'b1;
    step(2'b10, 2'b01);
    step(2'b10, 2'b01);
    chk("rst_restart", {8'd0, bcd_b}, 32'h000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
